// File: rtl/serial_slice_adder_pkg.sv
// Shared constants for the serial slice adder: FSM encodings and slice width.
package serial_slice_adder_pkg;

    localparam int unsigned SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_slice_adder_slice.sv
// Slice datapath: a 2-bit ripple adder with external carry-in, built from two full adders.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    always_comb begin
        Sum  = A ^ B ^ Cin;
        Cout = (A & B) | (Cin & (A ^ B));
    end

endmodule

module adder_2bit_ci
    import serial_slice_adder_pkg::*;
(
    output logic [SLICE_W-1:0] Sum,
    output logic               Cout,
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin
);

    logic c_mid;

    full_adder u_fa0 (
        .A    (A[0]),
        .B    (B[0]),
        .Cin  (Cin),
        .Sum  (Sum[0]),
        .Cout (c_mid)
    );

    full_adder u_fa1 (
        .A    (A[1]),
        .B    (B[1]),
        .Cin  (c_mid),
        .Sum  (Sum[1]),
        .Cout (Cout)
    );

endmodule

// File: rtl/serial_slice_adder.sv
// Sequential WIDTH-bit adder: two bits per cycle through adder_2bit_ci, carry kept in a register.
module serial_slice_adder
    import serial_slice_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry
);

    localparam int unsigned SLICES = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_t state, state_next;

    logic [WIDTH-1:0]   a_sh, b_sh, r_sh, r_next;
    logic               carry_reg;
    logic [CNT_W-1:0]   count;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept, last;

    adder_2bit_ci u_slice (
        .Sum  (slice_sum),
        .Cout (slice_cout),
        .A    (a_sh[SLICE_W-1:0]),
        .B    (b_sh[SLICE_W-1:0]),
        .Cin  (carry_reg)
    );

    assign accept = Start && ((state == IDLE) || (state == DONE));
    assign last   = (count == CNT_W'(SLICES - 1));
    // Shift form keeps a single expression valid down to WIDTH == SLICE_W.
    assign r_next = (r_sh >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = ADD;
            ADD:     if (last)  state_next = DONE;
            DONE:    state_next = Start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == ADD);
        Done = (state == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry_reg <= 1'b0;
            count     <= '0;
            Result    <= '0;
            Carry     <= 1'b0;
        end else if (accept) begin
            a_sh      <= A;
            b_sh      <= B;
            carry_reg <= 1'b0;
            count     <= '0;
        end else if (state == ADD) begin
            a_sh      <= a_sh >> SLICE_W;
            b_sh      <= b_sh >> SLICE_W;
            r_sh      <= r_next;
            carry_reg <= slice_cout;
            count     <= count + CNT_W'(1);
            if (last) begin
                Result <= r_next;
                Carry  <= slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_slice_adder.sv
// Directed bench for serial_slice_adder: an 8-bit and a 2-bit instance on one clock.
module tb_serial_slice_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [7:0] a, b;
    logic [1:0] a2, b2;
    logic       busy, done, carry;
    logic [7:0] result;
    logic       busy2, done2, carry2;
    logic [1:0] result2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_slice_adder #(.WIDTH(8)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .A(a), .B(b),
        .Busy(busy), .Done(done), .Result(result), .Carry(carry)
    );

    serial_slice_adder #(.WIDTH(2)) dut2 (
        .Clk(clk), .Rst(rst), .Start(start2), .A(a2), .B(b2),
        .Busy(busy2), .Done(done2), .Result(result2), .Carry(carry2)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
        end
        checks++;
        if ({carry, result} !== 9'h000) begin
            errors++; $display("FAIL reset_result: carry/result=%h expected 000", {carry, result});
        end
        checks++;
        if ({busy2, done2, carry2, result2} !== 5'b00000) begin
            errors++; $display("FAIL reset_w2: got %b expected 00000", {busy2, done2, carry2, result2});
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        start = 1'b1; a = 8'h5A; b = 8'h33;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++; $display("FAIL basic_busy%0d: busy/done=%b expected 10", i, {busy, done});
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL basic_done: busy/done=%b expected 01", {busy, done});
        end
        checks++;
        if ({carry, result} !== 9'h08D) begin
            errors++; $display("FAIL basic_sum: carry/result=%h expected 08d", {carry, result});
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL basic_idle: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_carry_ripple();
        start = 1'b1; a = 8'hFF; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({carry, result} !== 9'h08D) begin
            errors++; $display("FAIL carry_hold_old: carry/result=%h expected 08d", {carry, result});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++; $display("FAIL carry_busy%0d: busy/done=%b expected 10", i, {busy, done});
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, done, carry, result} !== 11'b01_1_0000_0000) begin
            errors++; $display("FAIL carry_done: busy/done/carry/result=%b expected 01100000000",
                               {busy, done, carry, result});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL carry_done_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL ignore_busy: busy=%b expected 1", busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({done, carry, result} !== 10'b1_0_0011_0000) begin
            errors++; $display("FAIL ignore_sum: done/carry/result=%b expected 1000110000", {done, carry, result});
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL ignore_no_restart: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        a = 8'h80; b = 8'h80;
        repeat (4) @(negedge clk);
        checks++;
        if ({done, carry, result} !== 10'b1_0_0000_0011) begin
            errors++; $display("FAIL b2b_first: done/carry/result=%b expected 1000000011", {done, carry, result});
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, carry, result} !== 11'b10_0_0000_0011) begin
            errors++; $display("FAIL b2b_restart: busy/done/carry/result=%b expected 10000000011",
                               {busy, done, carry, result});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++; $display("FAIL b2b_busy%0d: busy/done=%b expected 10", i, {busy, done});
            end
        end
        @(negedge clk);
        checks++;
        if ({done, carry, result} !== 10'b1_1_0000_0000) begin
            errors++; $display("FAIL b2b_second: done/carry/result=%b expected 1100000000", {done, carry, result});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, carry, result} !== 11'b0) begin
            errors++; $display("FAIL midrst_state: busy/done/carry/result=%b expected 0", {busy, done, carry, result});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++; $display("FAIL midrst_quiet%0d: busy/done=%b expected 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_width2();
        start2 = 1'b1; a2 = 2'b11; b2 = 2'b11;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if ({busy2, done2} !== 2'b10) begin
            errors++; $display("FAIL w2_busy: busy/done=%b expected 10", {busy2, done2});
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2, carry2, result2} !== 5'b01_1_10) begin
            errors++; $display("FAIL w2_done: busy/done/carry/result=%b expected 01110", {busy2, done2, carry2, result2});
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b0) begin
            errors++; $display("FAIL w2_done_pulse: done=%b expected 0", done2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_width2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
